vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, input, 1, 50 MHz system clock
- reset, input, 1, synchronous active-high reset
- rgb_in, input, 8, pixel colour from the downstream renderer for the current x/y
- x, output, 11, current column, 0..H_total-1
- y, output, 11, current row, 0..V_total-1
- pix_tick, output, 1, one-clk pulse marking the first clk of each pixel
- video_on, output, 1, high when x<H_VIS and y<V_VIS
- frame_start, output, 1, one-clk pulse when x=0, y=0 and pix_tick are all asserted
- hsync, output, 1, active-low, aligned with rgb_out
- vsync, output, 1, active-low, aligned with rgb_out
- rgb_out, output, 8, registered colour to the DAC, forced to 0 in blanking
- frame_cnt, output, 16, frames completed (see Configuration)
REQ-003 SHALL use one clock (clk) and a synchronous, active-high reset (reset); all flops SHALL update only on the rising edge of clk.

Function
REQ-004 SHALL run a 1-bit phase toggle: pix_tick=1 when phase=0, giving a 25 MHz pixel rate. Each pixel lasts exactly 2 clk.
REQ-005 SHALL increment x on each clk where pix_tick=1. At x=H_total-1 (799 at default), x SHALL wrap to 0 and y SHALL increment.
REQ-006 SHALL wrap y to 0 at V_total-1 (524) when x wraps; x and y SHALL change together on the same clk.
REQ-007 x and y SHALL be stable for both clk of a pixel, so the renderer's 1-clk registered rgb is valid on the second clk.
REQ-008 SHALL sample rgb_in into rgb_out on the second clk of each pixel (pix_tick=0). Capture is video_on-gated: sampled value if video_on, else 8'h00.
REQ-009 SHALL compute raw sync from x/y:
- hsync low for H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC (656..751)
- vsync low for V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC (490..491)
REQ-010 SHALL register hsync/vsync at the same clk as rgb_out (1-clk output latency), keeping sync and colour pixel-aligned.
REQ-011 frame_start SHALL be combinational from the counters and phase, asserted exactly once per 840000 clk.
REQ-012 Counter widths SHALL be 11 bits; sum overflow is impossible for any legal parameter set with H_total, V_total <= 2047.

Reset
REQ-013 While reset=1, the outputs SHALL be held as follows: phase=0, x=0, y=0, rgb_out=0, hsync=1, vsync=1, frame_cnt=0.
REQ-014 Reset asserted mid-line SHALL take effect on the next clk edge and discard the partial frame. The first pix_tick after release SHALL occur on the first clk with reset=0.

Configuration
REQ-015 Macro VGA_FRAME_CNT_EN controls frame_cnt:
- defined: frame_cnt increments by 1, modulo 2^16, on each clk with frame_start=1, excluding the first frame_start after reset
- undefined: frame_cnt is constant 0 and no counter flops are synthesized

Verification
REQ-016 Reset for 3 clk, then release -> x=0, y=0, hsync=1, vsync=1, rgb_out=0, pix_tick=1 on first clk.
REQ-017 Run 1600 clk -> x reaches 799 then wraps to 0 with y=1; pix_tick toggles every clk.
REQ-018 Hold rgb_in=8'hD0 for a full line -> rgb_out=8'hD0 for x=0..639 (1 clk delayed) and 0 for x=640..799.
REQ-019 Observe a full frame -> hsync low for exactly 192 clk per line starting at x=656; vsync low for lines 490-491 only (3200 clk).
REQ-020 Assert reset at x=300, y=200 for 1 clk -> next clk x=0, y=0, rgb_out=0, hsync=vsync=1.
REQ-021 With VGA_FRAME_CNT_EN, run 3 full frames -> frame_cnt=2 after the third frame_start; without the macro, frame_cnt=0 throughout.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator: 2-clk pixels, x/y counters, registered sync and blanked colour.
// Latency: hsync/vsync/rgb_out lag the x/y position by one pixel (registered on the pixel's second clk).
// Backpressure: none; free-running raster. Optional macro VGA_FRAME_CNT_EN adds the frame counter.
module vga_timing_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rgb_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        pix_tick,
    output logic        video_on,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  rgb_out,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
    localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

    // phase=0 is the first clk of a pixel; reset parks it there so the first
    // clk after release already carries pix_tick.
    logic phase;
    logic hsync_raw;
    logic vsync_raw;

    // Pixel phase toggle: one pixel every two clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    assign pix_tick = ~phase;

    // Raster counters advance at the end of a pixel, so a new x/y appears
    // together with pix_tick and stays put for both clk of the pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (phase) begin
            if (x == H_LAST) begin
                x <= '0;
                y <= (y == V_LAST) ? 11'd0 : y + 11'd1;
            end else begin
                x <= x + 11'd1;
            end
        end
    end

    assign video_on    = (x < H_VIS_W) && (y < V_VIS_W);
    assign frame_start = pix_tick && (x == 11'd0) && (y == 11'd0);
    assign hsync_raw   = ~((x >= HS_START) && (x < HS_END));
    assign vsync_raw   = ~((y >= VS_START) && (y < VS_END));

    // Colour and sync are captured together on the pixel's second clk, when the
    // renderer's registered colour for this x/y is valid; blanking forces black.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out <= 8'h00;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else if (phase) begin
            rgb_out <= video_on ? rgb_in : 8'h00;
            hsync   <= hsync_raw;
            vsync   <= vsync_raw;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // The frame_start right after reset begins the first frame rather than
    // completing one, so it only arms the counter.
    logic armed;

    // Completed-frame counter, wraps modulo 2^16.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= 16'd0;
            armed     <= 1'b0;
        end else if (frame_start) begin
            if (armed) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            armed <= 1'b1;
        end
    end
`else
    assign frame_cnt = 16'd0;
`endif

endmodule
